// File: rtl/fifo_stream_pkg.sv
// ============================================================================
// fifo_stream_pkg : shared types and constants for the FIFO read streamer
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_stream_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int BUF_DEPTH      = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Occupancy as a word count, widened so credit arithmetic cannot wrap.
    function automatic logic [2:0] occ_count(input occ_t occ);
        return {1'b0, occ};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// ============================================================================
// fifo_skid_buf : 2-entry output buffer with 1-bit wrapping pointers
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head
);

    occ_t                  r_occ;
    occ_t                  w_occ_nxt;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= EMPTY;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    // Push and pop together leave occupancy unchanged.
    always_comb begin
        w_occ_nxt = r_occ;
        case ({push, pop})
            2'b10: begin
                case (r_occ)
                    EMPTY:   w_occ_nxt = ONE;
                    ONE:     w_occ_nxt = TWO;
                    default: w_occ_nxt = r_occ;
                endcase
            end
            2'b01: begin
                case (r_occ)
                    TWO:     w_occ_nxt = ONE;
                    ONE:     w_occ_nxt = EMPTY;
                    default: w_occ_nxt = r_occ;
                endcase
            end
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    assign occ  = r_occ;
    assign head = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_streamer.sv
// ============================================================================
// fifo_rd_streamer : drains a synchronous FIFO into a valid/ready stream
// Optional word counter under macro FIFO_RD_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  underflow_err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           word_count
`endif
);

    occ_t       w_occ;
    logic       r_inflight;
    logic       r_underflow_err;
    logic       w_pop;
    logic       w_push;
    logic [2:0] w_credit_used;

    assign m_valid = (w_occ != EMPTY);
    assign w_pop   = m_valid & m_ready;
    assign w_push  = r_inflight & ~fifo_underflow;

    // Slots committed after this cycle's pop; the same-cycle pop frees a slot.
    assign w_credit_used = occ_count(w_occ) + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en    = rst_n & ~fifo_empty & (w_credit_used < 3'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (r_inflight && fifo_underflow) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign underflow_err = r_underflow_err;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (fifo_data_out),
        .pop       (w_pop),
        .occ       (w_occ),
        .head      (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (w_pop && (r_word_count != '1)) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_rd_streamer.md
# fifo_rd_streamer

- Read-side stage placed directly downstream of the synchronous FIFO.
- Drains the FIFO through its `rd_en`/`data_out`/`empty`/`underflow` interface and presents the words as a valid/ready stream.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so downstream back-pressure never loses a word and a word is sustained every cycle when `m_ready` is held high.

## Interface
Parameters:
- `DATA_WIDTH`, default 16: word width; matches the FIFO data width.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_underflow`  in  1: FIFO underflow flag; valid the cycle after a read.
- `fifo_data_out`  in  DATA_WIDTH: FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1: read request to the FIFO; combinational.
- `m_valid`  out  1: output word available.
- `m_data`  out  DATA_WIDTH: output word (head of buffer).
- `m_ready`  in  1: downstream accepts the word.
- `underflow_err`  out  1: sticky; set when a read returned underflow.
- `word_count`  out  32: words delivered. Present only under `FIFO_RD_STATS_EN`.

## Operation
- Output buffer: 2 entries, occupancy state EMPTY / ONE / TWO, with 1-bit write and read pointers.
- `inflight` register: set to `fifo_rd_en` each cycle; marks a word arriving from the FIFO in the current cycle.
- Pop: `pop = m_valid & m_ready`.
- Read request: `fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2`.
  - Credit from the same-cycle pop allows one word per cycle.
  - Widen the arithmetic to 3 bits before subtracting.
- Capture: when `inflight` is set and `fifo_underflow` is low, write `fifo_data_out` into the buffer at the write pointer.
- Underflow: when `inflight` is set and `fifo_underflow` is high:
  - discard the data and do not push;
  - set `underflow_err`. It is cleared only by reset.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers wrap 1→0.
- Output: `m_valid = (occ != EMPTY)` and `m_data = buf[rd_ptr]`, both from registers.
- `m_data` holds its value while `m_valid && !m_ready`.
- Words are delivered in strict FIFO order; none is duplicated or dropped, except the underflow discard.
- Overflow of the buffer is impossible by construction. The bench asserts `occ + inflight <= 2` every cycle.

## Timing
- Reset values:
  - `fifo_rd_en` = 0 (forced while `rst_n` is low);
  - `m_valid` = 0;
  - `m_data` = 0;
  - `underflow_err` = 0;
  - `word_count` = 0;
  - occupancy EMPTY, pointers 0, `inflight` 0.
- Latency: `fifo_rd_en` high in cycle N → data captured at the end of N+1 → `m_valid` high in N+2.
- Throughput: 1 word/cycle while the FIFO is non-empty and `m_ready` stays high.
- Back-pressure: with `m_ready` low, reads stop once `occ + inflight` = 2. At most 2 words are held.
- Reset mid-operation: the in-flight word and buffered words are discarded. Output returns to the reset values asynchronously.
- FIFO goes empty mid-stream: `fifo_rd_en` drops in the same cycle. `m_valid` falls after the last buffered word is popped.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `word_count` port exists;
  - it increments by 1 on each pop and saturates at 2^32-1.
- `FIFO_RD_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_stream_pkg`:
  - `DATA_WIDTH_DEF` = 16;
  - `occ_t` enum {EMPTY, ONE, TWO};
  - `BUF_DEPTH` = 2.
- Sub-module `fifo_skid_buf`: the 2-entry buffer.
  - Inputs: push, push_data, pop.
  - Outputs: occ, head data.
- The top level holds the credit logic, `inflight`, the underflow flag and the stats counter.

## Test plan
- Reset with the FIFO holding 3 words (0x0011, 0x0022, 0x0033) and `m_ready`=1 → `fifo_rd_en` rises in cycle 0; `m_valid` in cycles 2–4 with data 0x0011, 0x0022, 0x0033; then `m_valid`=0.
- `m_ready`=0 with 8 words in the FIFO → exactly 2 reads are issued and `m_valid` holds 0x0011. Releasing `m_ready` drains all 8 in order, one per cycle.
- Toggle `m_ready` 1,0,1,0 over a 6-word stream → output order is intact; `occ + inflight <= 2` holds every cycle.
- Force `fifo_underflow`=1 in the cycle after a read → no push; `underflow_err`=1 and stays set until `rst_n`=0.
- Assert `rst_n`=0 mid-stream with 2 words buffered and 1 in flight → `m_valid`=0 and `fifo_rd_en`=0 immediately. After release, the first word out is the next FIFO word.
- With `FIFO_RD_STATS_EN`: deliver 5 words → `word_count`=5. A reset → 0.
